// File: rtl/dcache_port_arbiter.sv
// Single data-cache port shared by the load pipeline and store-queue commit.
// One access in flight; store-first priority with a bounded load starvation window.
module dcache_port_arbiter #(
    parameter int PD_W         = 6,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_ld_valid,
    output logic            o_ld_ready,
    input  logic [31:0]     i_ld_addr,
    input  logic [3:0]      i_ld_rmask,
    input  logic [PD_W-1:0] i_ld_pd,
    input  logic            i_st_valid,
    output logic            o_st_ready,
    input  logic [31:0]     i_st_addr,
    input  logic [3:0]      i_st_wmask,
    input  logic [31:0]     i_st_wdata,
    output logic [31:0]     o_dmem_addr,
    output logic [3:0]      o_dmem_rmask,
    output logic [3:0]      o_dmem_wmask,
    output logic [31:0]     o_dmem_wdata,
    input  logic [31:0]     i_dmem_rdata,
    input  logic            i_dmem_resp,
    output logic            o_ld_res_valid,
    output logic [PD_W-1:0] o_ld_res_pd,
    output logic [31:0]     o_ld_res_data,
    output logic            o_st_done
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LD_WAIT = 2'd1;
    localparam logic [1:0] S_ST_WAIT = 2'd2;
    localparam logic [1:0] S_LD_DROP = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [31:0]      r_addr;
    logic [3:0]       r_rmask;
    logic [3:0]       r_wmask;
    logic [31:0]      r_wdata;
    logic [PD_W-1:0]  r_pd;
    logic             r_ld_res_valid;
    logic [PD_W-1:0]  r_ld_res_pd;
    logic [31:0]      r_ld_res_data;
    logic             r_st_done;

    logic w_idle;
    logic w_ld_req;
    logic w_ld_wins;
    logic w_ld_grant;
    logic w_st_grant;

    // A flushed load never requests; a starved load overrides the store only at the limit.
    assign w_idle     = (r_state == S_IDLE);
    assign w_ld_req   = i_ld_valid && !i_flush;
    assign w_ld_wins  = (r_starve_cnt == LIMIT);
    assign w_st_grant = w_idle && i_st_valid && !(w_ld_req && w_ld_wins);
    assign w_ld_grant = w_idle && w_ld_req && (!i_st_valid || w_ld_wins);

    assign o_ld_ready     = w_ld_grant;
    assign o_st_ready     = w_st_grant;
    assign o_dmem_addr    = r_addr;
    assign o_dmem_rmask   = r_rmask;
    assign o_dmem_wmask   = r_wmask;
    assign o_dmem_wdata   = r_wdata;
    assign o_ld_res_valid = r_ld_res_valid;
    assign o_ld_res_pd    = r_ld_res_pd;
    assign o_ld_res_data  = r_ld_res_data;
    assign o_st_done      = r_st_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve_cnt <= '0;
        end else if (i_flush) begin
            r_starve_cnt <= '0;
        end else if (w_idle) begin
            if (!i_ld_valid || w_ld_grant)
                r_starve_cnt <= '0;
            else if (w_st_grant && !w_ld_wins)
                r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_rmask        <= '0;
            r_wmask        <= '0;
            r_wdata        <= '0;
            r_pd           <= '0;
            r_ld_res_valid <= 1'b0;
            r_ld_res_pd    <= '0;
            r_ld_res_data  <= '0;
            r_st_done      <= 1'b0;
        end else begin
            r_ld_res_valid <= 1'b0;
            r_st_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_st_grant) begin
                        r_state <= S_ST_WAIT;
                        r_addr  <= {i_st_addr[31:2], 2'b00};
                        r_rmask <= 4'b0000;
                        r_wmask <= i_st_wmask;
                        r_wdata <= i_st_wdata;
                    end else if (w_ld_grant) begin
                        r_state <= S_LD_WAIT;
                        r_addr  <= {i_ld_addr[31:2], 2'b00};
                        r_rmask <= i_ld_rmask;
                        r_wmask <= 4'b0000;
                        r_pd    <= i_ld_pd;
                    end
                end
                S_LD_WAIT: begin
                    if (i_dmem_resp) begin
                        r_state <= S_IDLE;
                        r_rmask <= 4'b0000;
                        // A squash landing with the response still kills the result.
                        if (!i_flush) begin
                            r_ld_res_valid <= 1'b1;
                            r_ld_res_pd    <= r_pd;
                            r_ld_res_data  <= i_dmem_rdata;
                        end
                    end else if (i_flush) begin
                        r_state <= S_LD_DROP;
                    end
                end
                S_LD_DROP: begin
                    if (i_dmem_resp) begin
                        r_state <= S_IDLE;
                        r_rmask <= 4'b0000;
                    end
                end
                S_ST_WAIT: begin
                    if (i_dmem_resp) begin
                        r_state   <= S_IDLE;
                        r_wmask   <= 4'b0000;
                        r_st_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
